// File: rtl/cpu_mc_pkg.sv
// Shared types, opcode constants and decode helpers for the multi-cycle RV32I core.
package cpu_mc_pkg;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALT
    } state_e;

    localparam logic [6:0] OP       = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] LOAD     = 7'b0000011;
    localparam logic [6:0] STORE    = 7'b0100011;
    localparam logic [6:0] BRANCH   = 7'b1100011;
    localparam logic [6:0] JAL      = 7'b1101111;
    localparam logic [6:0] JALR     = 7'b1100111;
    localparam logic [6:0] LUI      = 7'b0110111;
    localparam logic [6:0] AUIPC    = 7'b0010111;
    localparam logic [6:0] MISC_MEM = 7'b0001111;
    localparam logic [6:0] SYSTEM   = 7'b1110011;

    localparam logic [31:0] ECALL_INSTR  = 32'h0000_0073;
    localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND,
        ALU_PASS_B
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_type_e;

    function automatic logic [31:0] imm_gen(input logic [31:0] instr, input imm_type_e kind);
        logic [31:0] imm;
        case (kind)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'b0};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = 32'd0;
        endcase
        return imm;
    endfunction

    // Picks the addressed lane out of the read word and extends it per the load width.
    function automatic logic [31:0] load_extend(input logic [31:0] rdata, input logic [1:0] offset,
                                                input logic [2:0] funct3);
        logic [7:0]  lane_b;
        logic [15:0] lane_h;
        logic [31:0] result;
        lane_b = rdata[{offset, 3'b000} +: 8];
        lane_h = offset[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            3'b000:  result = {{24{lane_b[7]}}, lane_b};
            3'b001:  result = {{16{lane_h[15]}}, lane_h};
            3'b100:  result = {24'd0, lane_b};
            3'b101:  result = {16'd0, lane_h};
            default: result = rdata;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/cpu_mc_regfile.sv
// Register file: NUM_REGS x 32, two asynchronous read ports, one synchronous write port, x0 reads zero.
module cpu_mc_regfile #(
    parameter int NUM_REGS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata
);

    localparam int AW = (NUM_REGS == 16) ? 4 : 5;

    logic [31:0] regs [NUM_REGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= 32'd0;
            end
        end else if (we && (waddr != 5'd0)) begin
            regs[waddr[AW-1:0]] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : regs[raddr1[AW-1:0]];
    assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : regs[raddr2[AW-1:0]];

endmodule

// File: rtl/cpu_multicycle.sv
// Multi-cycle RV32I core sharing one valid/ready memory port between fetch and data access.
// Define CPU_MC_INSTRET_EN to add the cycle_cnt / instret_cnt performance counter ports.
module cpu_multicycle
    import cpu_mc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          NUM_REGS = 32
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [31:0] cpu_out,
`ifdef CPU_MC_INSTRET_EN
    output logic [63:0] cycle_cnt,
    output logic [63:0] instret_cnt,
`endif
    output logic        halted,
    output logic        trap
);

    state_e      state;
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] rs1_q;
    logic [31:0] rs2_q;
    logic [31:0] imm_q;
    logic [31:0] next_pc;
    logic [31:0] wb_val;
    logic        wb_en;

    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;

    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign funct3 = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign funct7 = ir[31:25];

    logic        legal;
    logic        uses_rs1;
    logic        uses_rs2;
    logic        uses_rd;
    imm_type_e   imm_kind;
    alu_op_e     alu_op;

    logic [31:0] rf_rdata1;
    logic [31:0] rf_rdata2;
    logic        rf_we;

    logic        is_load;
    logic        is_store;
    logic        is_ebreak;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] alu_result;
    logic        branch_taken;
    logic [31:0] link_pc;
    logic [31:0] next_pc_calc;
    logic [31:0] store_data;
    logic [3:0]  store_strb;
    logic        data_misaligned;

    cpu_mc_regfile #(
        .NUM_REGS(NUM_REGS)
    ) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .raddr1 (rs1),
        .raddr2 (rs2),
        .rdata1 (rf_rdata1),
        .rdata2 (rf_rdata2),
        .we     (rf_we),
        .waddr  (rd),
        .wdata  (wb_val)
    );

    assign rf_we = (state == WB) && wb_en && (rd != 5'd0);

    // Legality, immediate format and register usage; unused fields never trigger the RV32E check.
    always_comb begin
        legal    = 1'b0;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        uses_rd  = 1'b0;
        imm_kind = IMM_NONE;
        case (opcode)
            OP: begin
                legal    = (funct7 == 7'h00) ||
                           ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                uses_rd  = 1'b1;
            end
            OP_IMM: begin
                if (funct3 == 3'b001) begin
                    legal = (funct7 == 7'h00);
                end else if (funct3 == 3'b101) begin
                    legal = (funct7 == 7'h00) || (funct7 == 7'h20);
                end else begin
                    legal = 1'b1;
                end
                imm_kind = IMM_I;
                uses_rs1 = 1'b1;
                uses_rd  = 1'b1;
            end
            LOAD: begin
                legal    = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
                imm_kind = IMM_I;
                uses_rs1 = 1'b1;
                uses_rd  = 1'b1;
            end
            STORE: begin
                legal    = funct3 inside {3'b000, 3'b001, 3'b010};
                imm_kind = IMM_S;
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            BRANCH: begin
                legal    = (funct3 != 3'b010) && (funct3 != 3'b011);
                imm_kind = IMM_B;
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            JAL: begin
                legal    = 1'b1;
                imm_kind = IMM_J;
                uses_rd  = 1'b1;
            end
            JALR: begin
                legal    = (funct3 == 3'b000);
                imm_kind = IMM_I;
                uses_rs1 = 1'b1;
                uses_rd  = 1'b1;
            end
            LUI, AUIPC: begin
                legal    = 1'b1;
                imm_kind = IMM_U;
                uses_rd  = 1'b1;
            end
            MISC_MEM: legal = 1'b1;
            SYSTEM:   legal = (ir == ECALL_INSTR) || (ir == EBREAK_INSTR);
            default:  legal = 1'b0;
        endcase
        if (NUM_REGS == 16) begin
            if ((uses_rs1 && rs1[4]) || (uses_rs2 && rs2[4]) || (uses_rd && rd[4])) begin
                legal = 1'b0;
            end
        end
    end

    always_comb begin
        alu_op = ALU_ADD;
        case (opcode)
            OP, OP_IMM: begin
                case (funct3)
                    3'b000:  alu_op = ((opcode == OP) && funct7[5]) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_op = ALU_SLL;
                    3'b010:  alu_op = ALU_SLT;
                    3'b011:  alu_op = ALU_SLTU;
                    3'b100:  alu_op = ALU_XOR;
                    3'b101:  alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_op = ALU_OR;
                    default: alu_op = ALU_AND;
                endcase
            end
            LUI:     alu_op = ALU_PASS_B;
            default: alu_op = ALU_ADD;
        endcase
    end

    assign is_load   = (opcode == LOAD);
    assign is_store  = (opcode == STORE);
    assign is_ebreak = (ir == EBREAK_INSTR);
    assign op_a      = (opcode == AUIPC) ? pc : rs1_q;
    assign op_b      = (opcode == OP) ? rs2_q : imm_q;
    assign link_pc   = pc + 32'd4;

    always_comb begin
        case (alu_op)
            ALU_ADD:    alu_result = op_a + op_b;
            ALU_SUB:    alu_result = op_a - op_b;
            ALU_SLL:    alu_result = op_a << op_b[4:0];
            ALU_SLT:    alu_result = {31'd0, $signed(op_a) < $signed(op_b)};
            ALU_SLTU:   alu_result = {31'd0, op_a < op_b};
            ALU_XOR:    alu_result = op_a ^ op_b;
            ALU_SRL:    alu_result = op_a >> op_b[4:0];
            ALU_SRA:    alu_result = $unsigned($signed(op_a) >>> op_b[4:0]);
            ALU_OR:     alu_result = op_a | op_b;
            ALU_AND:    alu_result = op_a & op_b;
            ALU_PASS_B: alu_result = op_b;
            default:    alu_result = op_a + op_b;
        endcase
    end

    always_comb begin
        case (funct3)
            3'b000:  branch_taken = (rs1_q == rs2_q);
            3'b001:  branch_taken = (rs1_q != rs2_q);
            3'b100:  branch_taken = ($signed(rs1_q) < $signed(rs2_q));
            3'b101:  branch_taken = ($signed(rs1_q) >= $signed(rs2_q));
            3'b110:  branch_taken = (rs1_q < rs2_q);
            3'b111:  branch_taken = (rs1_q >= rs2_q);
            default: branch_taken = 1'b0;
        endcase
    end

    always_comb begin
        next_pc_calc = link_pc;
        if ((opcode == JAL) || ((opcode == BRANCH) && branch_taken)) begin
            next_pc_calc = pc + imm_q;
        end else if (opcode == JALR) begin
            next_pc_calc = (rs1_q + imm_q) & ~32'd1;
        end
    end

    // Store data is replicated across lanes so the strobe alone selects the target bytes.
    always_comb begin
        store_data      = rs2_q;
        store_strb      = 4'b1111;
        data_misaligned = 1'b0;
        case (funct3[1:0])
            2'b00: begin
                store_data = {4{rs2_q[7:0]}};
                store_strb = 4'b0001 << alu_result[1:0];
            end
            2'b01: begin
                store_data      = {2{rs2_q[15:0]}};
                store_strb      = alu_result[1] ? 4'b1100 : 4'b0011;
                data_misaligned = alu_result[0];
            end
            2'b10: data_misaligned = |alu_result[1:0];
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            ir        <= 32'd0;
            rs1_q     <= 32'd0;
            rs2_q     <= 32'd0;
            imm_q     <= 32'd0;
            next_pc   <= RESET_PC;
            wb_val    <= 32'd0;
            wb_en     <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= RESET_PC;
            mem_wdata <= 32'd0;
            mem_wstrb <= 4'b0000;
            cpu_out   <= 32'd0;
            halted    <= 1'b0;
            trap      <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (!mem_req) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_wstrb <= 4'b0000;
                        mem_addr  <= pc;
                    end else if (mem_ready) begin
                        ir      <= mem_rdata;
                        mem_req <= 1'b0;
                        state   <= DECODE;
                    end
                end
                DECODE: begin
                    if (!legal) begin
                        halted <= 1'b1;
                        trap   <= 1'b1;
                        state  <= HALT;
                    end else begin
                        rs1_q <= rf_rdata1;
                        rs2_q <= rf_rdata2;
                        imm_q <= imm_gen(ir, imm_kind);
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    next_pc <= next_pc_calc;
                    wb_en   <= uses_rd;
                    wb_val  <= ((opcode == JAL) || (opcode == JALR)) ? link_pc : alu_result;
                    if (is_ebreak) begin
                        halted <= 1'b1;
                        state  <= HALT;
                    end else if (((is_load || is_store) && data_misaligned) || next_pc_calc[1]) begin
                        halted <= 1'b1;
                        trap   <= 1'b1;
                        state  <= HALT;
                    end else if (is_load || is_store) begin
                        mem_req   <= 1'b1;
                        mem_we    <= is_store;
                        mem_addr  <= alu_result;
                        mem_wdata <= store_data;
                        mem_wstrb <= is_store ? store_strb : 4'b0000;
                        state     <= MEM;
                    end else begin
                        state <= WB;
                    end
                end
                MEM: begin
                    if (mem_ready) begin
                        if (is_load) begin
                            wb_val <= load_extend(mem_rdata, mem_addr[1:0], funct3);
                        end
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_wstrb <= 4'b0000;
                        state     <= WB;
                    end
                end
                WB: begin
                    if (wb_en && (rd != 5'd0)) begin
                        cpu_out <= wb_val;
                    end
                    pc        <= next_pc;
                    mem_req   <= 1'b1;
                    mem_we    <= 1'b0;
                    mem_wstrb <= 4'b0000;
                    mem_addr  <= next_pc;
                    state     <= FETCH;
                end
                HALT: begin
                    mem_req <= 1'b0;
                end
                default: state <= HALT;
            endcase
        end
    end

`ifdef CPU_MC_INSTRET_EN
    // Counters run through HALT; retirement is counted on leaving WB.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt   <= 64'd0;
            instret_cnt <= 64'd0;
        end else begin
            cycle_cnt <= cycle_cnt + 64'd1;
            if (state == WB) begin
                instret_cnt <= instret_cnt + 64'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cpu_multicycle.sv
// Directed self-checking bench for cpu_multicycle running a small program from a word memory model.
module tb_cpu_multicycle;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [31:0] cpu_out;
    logic        halted;
    logic        trap;
`ifdef CPU_MC_INSTRET_EN
    logic [63:0] cycle_cnt;
    logic [63:0] instret_cnt;
`endif

    logic [31:0] mem [256];
    int          check_count = 0;
    int          pass_count  = 0;
    int          fail_count  = 0;
    logic        saw_req;

    cpu_multicycle dut (
        .clk       (clk),
        .rst       (rst),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .cpu_out   (cpu_out),
`ifdef CPU_MC_INSTRET_EN
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt),
`endif
        .halted    (halted),
        .trap      (trap)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[9:2]];

    task automatic applyStimulus(input logic reset_val, input logic ready_val);
        rst       = reset_val;
        mem_ready = ready_val;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Waits (bounded) for an instruction fetch request at addr, leaving the bench on that negedge.
    task automatic waitFetch(input logic [31:0] addr, input string tag);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (mem_req && !mem_we && (mem_addr == addr)) found = 1'b1;
        end
        checkOutput({tag, " fetch reached"}, {31'd0, found}, 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0013;
        mem[0]  = 32'h0050_0093;  // 0x00 ADDI x1,x0,5
        mem[1]  = 32'h1000_0113;  // 0x04 ADDI x2,x0,0x100
        mem[2]  = 32'h0A50_0193;  // 0x08 ADDI x3,x0,0xA5
        mem[3]  = 32'h0021_1203;  // 0x0C LH   x4,2(x2)
        mem[4]  = 32'h0021_5283;  // 0x10 LHU  x5,2(x2)
        mem[5]  = 32'h0031_0123;  // 0x14 SB   x3,2(x2)
        mem[6]  = 32'h0003_9863;  // 0x18 BNE  x7,x0,+16
        mem[7]  = 32'h0010_0393;  // 0x1C ADDI x7,x0,1
        mem[8]  = 32'hFE00_0CE3;  // 0x20 BEQ  x0,x0,-8
        mem[10] = 32'h0400_0293;  // 0x28 ADDI x5,x0,0x40
        mem[11] = 32'h0012_80E7;  // 0x2C JALR x1,x5,1
        mem[16] = 32'h4030_0433;  // 0x40 SUB  x8,x0,x3
        mem[17] = 32'h4044_5493;  // 0x44 SRAI x9,x8,4
        mem[18] = 32'h0080_3533;  // 0x48 SLTU x10,x0,x8
        mem[19] = 32'h0004_25B3;  // 0x4C SLT  x11,x8,x0
        mem[20] = 32'h0021_2603;  // 0x50 LW   x12,2(x2) misaligned
        mem[64] = 32'h8001_0000;  // data word at 0x100

        $display("[TB] starting cpu_multicycle directed test");
        applyStimulus(1'b1, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset mem_req", {31'd0, mem_req}, 32'd0);
        checkOutput("reset mem_we", {31'd0, mem_we}, 32'd0);
        checkOutput("reset mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
        checkOutput("reset cpu_out", cpu_out, 32'd0);
        checkOutput("reset halted", {31'd0, halted}, 32'd0);
        checkOutput("reset trap", {31'd0, trap}, 32'd0);

        // First fetch held in wait states for three full cycles.
        applyStimulus(1'b0, 1'b0);
        for (int i = 0; i < 5 && !mem_req; i++) @(negedge clk);
        checkOutput("ws req c1", {31'd0, mem_req}, 32'd1);
        checkOutput("ws addr c1", mem_addr, 32'h0);
        for (int i = 2; i <= 4; i++) begin
            @(negedge clk);
            checkOutput($sformatf("ws req c%0d", i), {31'd0, mem_req}, 32'd1);
            checkOutput($sformatf("ws addr c%0d", i), mem_addr, 32'h0);
        end
        checkOutput("ws cpu_out", cpu_out, 32'd0);
        mem_ready = 1'b1;

        // ADDI takes four cycles; the next fetch request appears right after WB.
        repeat (4) @(negedge clk);
        checkOutput("addi next req", {31'd0, mem_req}, 32'd1);
        checkOutput("addi next addr", mem_addr, 32'h4);
        checkOutput("addi cpu_out", cpu_out, 32'd5);

        waitFetch(32'h08, "x2");
        checkOutput("x2 value", cpu_out, 32'h100);
        waitFetch(32'h0C, "x3");
        checkOutput("x3 value", cpu_out, 32'hA5);
        waitFetch(32'h10, "lh");
        checkOutput("lh value", cpu_out, 32'hFFFF_8001);
        waitFetch(32'h14, "lhu");
        checkOutput("lhu value", cpu_out, 32'h0000_8001);

        saw_req = 1'b0;
        for (int i = 0; i < 10 && !saw_req; i++) begin
            @(negedge clk);
            if (mem_req && mem_we) saw_req = 1'b1;
        end
        checkOutput("sb request", {31'd0, saw_req}, 32'd1);
        checkOutput("sb addr", mem_addr, 32'h102);
        checkOutput("sb wstrb", {28'd0, mem_wstrb}, 32'h4);
        checkOutput("sb wdata", mem_wdata, 32'hA5A5_A5A5);

        waitFetch(32'h18, "after sb");
        checkOutput("sb no rd write", cpu_out, 32'h0000_8001);
        waitFetch(32'h1C, "bne not taken");
        waitFetch(32'h20, "x7");
        checkOutput("x7 value", cpu_out, 32'd1);
        waitFetch(32'h18, "beq target");
        waitFetch(32'h28, "bne taken");
        waitFetch(32'h2C, "x5");
        checkOutput("x5 value", cpu_out, 32'h40);
        waitFetch(32'h40, "jalr target");
        checkOutput("jalr link", cpu_out, 32'h30);
        waitFetch(32'h44, "sub");
        checkOutput("sub value", cpu_out, 32'hFFFF_FF5B);
        waitFetch(32'h48, "srai");
        checkOutput("srai value", cpu_out, 32'hFFFF_FFF5);
        waitFetch(32'h4C, "sltu");
        checkOutput("sltu value", cpu_out, 32'd1);
        waitFetch(32'h50, "slt");
        checkOutput("slt value", cpu_out, 32'd1);

        // Misaligned LW must halt with trap without ever touching the bus.
        saw_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (mem_req) saw_req = 1'b1;
        end
        checkOutput("lw halted", {31'd0, halted}, 32'd1);
        checkOutput("lw trap", {31'd0, trap}, 32'd1);
        checkOutput("lw no request", {31'd0, saw_req}, 32'd0);
        checkOutput("lw cpu_out kept", cpu_out, 32'd1);

        // Reset clears the sticky halt, then a reset during MEM drops the request.
        applyStimulus(1'b1, 1'b1);
        repeat (2) @(negedge clk);
        applyStimulus(1'b0, 1'b1);
        checkOutput("rerun halted", {31'd0, halted}, 32'd0);
        checkOutput("rerun trap", {31'd0, trap}, 32'd0);
        waitFetch(32'h00, "rerun start");
        waitFetch(32'h0C, "rerun lh");
        @(negedge clk);
        mem_ready = 1'b0;
        saw_req = 1'b0;
        for (int i = 0; i < 6 && !saw_req; i++) begin
            @(negedge clk);
            if (mem_req) saw_req = 1'b1;
        end
        checkOutput("mem request", {31'd0, saw_req}, 32'd1);
        checkOutput("mem addr", mem_addr, 32'h102);
        checkOutput("mem read wstrb", {28'd0, mem_wstrb}, 32'd0);
        @(negedge clk);
        checkOutput("mem held req", {31'd0, mem_req}, 32'd1);
        checkOutput("mem held addr", mem_addr, 32'h102);
        applyStimulus(1'b1, 1'b0);
        @(negedge clk);
        checkOutput("rst drops req", {31'd0, mem_req}, 32'd0);
        checkOutput("rst cpu_out", cpu_out, 32'd0);
        applyStimulus(1'b0, 1'b1);
        waitFetch(32'h00, "restart");
        waitFetch(32'h04, "restart addi");
        checkOutput("restart cpu_out", cpu_out, 32'd5);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
